// File: rtl/expander_fifo_pkg.sv
// Shared constants for the expander FIFO: status-word bit positions and
// the write-1 command bits decoded from status_load/load_data.
package expander_fifo_pkg;

    localparam int DATA_W = 16;

    // Status word bit positions
    localparam int ST_OVF   = 15;
    localparam int ST_FULL  = 14;
    localparam int ST_EMPTY = 13;
    localparam int ST_UNF   = 12;

    // Command bits carried on load_data when status_load is strobed
    localparam int CMD_CLR_OVF = 15;
    localparam int CMD_FLUSH   = 14;
    localparam int CMD_CLR_UNF = 12;

    // Count occupies the low bits; it never exceeds AW+1 bits, so bits above stay zero.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic       unf,
        input logic [8:0] count
    );
        logic [DATA_W-1:0] s;
        s           = '0;
        s[8:0]      = count;
        s[ST_OVF]   = ovf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_UNF]   = unf;
        return s;
    endfunction

endpackage

// File: rtl/expander_fifo_mem.sv
// FIFO storage: DEPTH x 16 array, synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the controller masks the output when empty.
module fifo_mem
    import expander_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/expander_fifo.sv
// Show-ahead FIFO presented to a bus expander as a data register (pop on read)
// and a status register (sticky flags, write-1-to-clear, flush command).
module expander_fifo
    import expander_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_r,
    input  logic              data_read,
    output logic [DATA_W-1:0] status_r,
    input  logic              status_load,
    input  logic [DATA_W-1:0] load_data,
    output logic              not_empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_full;
    logic              w_empty;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_ovf_clr;
    logic              w_unf_clr;
    logic [DATA_W-1:0] w_rdata;
    logic [8:0]        w_count9;
    logic              w_unused;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);

    assign w_flush   = status_load & load_data[CMD_FLUSH];
    assign w_ovf_clr = status_load & load_data[CMD_CLR_OVF];
    assign w_unf_clr = status_load & load_data[CMD_CLR_UNF];

    // Flush discards any same-edge push/pop, but the error flags still record the attempt.
    assign w_push    = in_valid  & ~w_full  & ~w_flush;
    assign w_pop     = data_read & ~w_empty & ~w_flush;
    assign w_ovf_set = in_valid  & w_full;
    assign w_unf_set = data_read & w_empty;

    assign w_unused  = ^{load_data[13], load_data[11:0]};

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_unf <= w_unf_set | (r_unf & ~w_unf_clr);
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (sysclk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (in_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_count9        = '0;
        w_count9[AW:0]  = r_count;
    end

    assign in_ready  = ~w_full;
    assign not_empty = ~w_empty;
    assign data_r    = w_empty ? '0 : w_rdata;
    assign status_r  = pack_status(r_ovf, w_full, w_empty, r_unf, w_count9);

endmodule
